tug_round_controller: RTL and testbench
=======================================

# tug_round_controller

Round sequencer and push arbiter for the Tug of War game. It consumes the two already-synchronized player push signals. Each round it decides which push counts: it runs a dark/lit cycle, penalizes false starts and resolves simultaneous presses. It maintains the rope position and declares a winner, driving the LED/display logic downstream.

## Interface
- DARK_CYCLES, 16, cycles spent in DARK before the go light; legal range 2..65535.
- SHOW_CYCLES, 4, cycles spent in SCORE while a point is displayed; legal range 1..65535.
- POS_MAX, 3, steps from centre to either end; legal range 1..7.
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-low reset.
- pbl  input  1  left player push, already synchronized to clk.
- pbr  input  1  right player push, already synchronized to clk.
- lit  output  1  go light; high only in LIT.
- pos  output  4  rope position 0..2*POS_MAX; centre is POS_MAX. 0 means the left player won; 2*POS_MAX means the right player won.
- score_l  output  1  one-cycle pulse when the left player gains a point.
- score_r  output  1  one-cycle pulse when the right player gains a point.
- winner  output  2  00 none, 01 left, 10 right; 11 never driven.
- state  output  2  00 DARK, 01 LIT, 10 SCORE, 11 WIN (debug).

## Operation
- Edge detect: registers prevl/prevr hold the previous pbl/pbr. A left edge is pbl=1 with prevl=0; the right side works the same way. Only edges count; holding a button has no further effect.
- prevl/prevr reset to 1. A button held through reset does not score until it is released and pressed again.
- DARK: a 16-bit counter cnt increments from 0.
  - At cnt==DARK_CYCLES-1 with no edge: go to LIT.
  - Left edge only: false start, so the right player scores (pos+1, score_r) and the block goes to SCORE.
  - Right edge only: the left player scores (pos-1, score_l) and the block goes to SCORE.
  - Both edges in the same cycle: no point; cnt restarts at 0 and the block stays in DARK.
  - An edge always takes precedence over counter expiry in the same cycle.
- LIT: waits indefinitely.
  - Left edge only: pos-1, score_l, go to SCORE.
  - Right edge only: pos+1, score_r, go to SCORE.
  - Both edges: tie; go to DARK with cnt=0 and no point.
- SCORE: all edges are ignored, but prevl/prevr still track the inputs. cnt runs from 0.
  - At cnt==SHOW_CYCLES-1: go to WIN if pos==0 or pos==2*POS_MAX, otherwise go to DARK with cnt=0.
- WIN: winner is set (01 if pos==0, 10 otherwise) and held along with pos. Edges are ignored. Only rst leaves this state.
- pos never underflows or overflows: scoring is only possible from DARK or LIT, and the block reaches WIN before any further score can occur.
- The counter clears on every state transition.

## Timing
- Reset (rst=0 at a rising edge) sets:
  - state=DARK, cnt=0, pos=POS_MAX;
  - lit=0, score_l=0, score_r=0, winner=00;
  - prevl=1, prevr=1.
- Reset takes priority over every state, including mid-SCORE and WIN.
- All outputs are registered. A transition decided at edge k is visible from cycle k+1.
- After reset is released, lit rises exactly DARK_CYCLES cycles later when no edges occur.
- Scoring: the edge is sampled at clock edge k. At that edge pos updates, the score pulse is set and state becomes SCORE. The pulse is high for cycle k+1 only.
- SCORE lasts exactly SHOW_CYCLES cycles; lit is 0 throughout.
- Push-to-point latency is 1 cycle from the push being sampled high to the score pulse.
- Maximum round length without a false start is DARK_CYCLES + SHOW_CYCLES cycles plus the time to the first push.

## Test plan
All scenarios use DARK_CYCLES=16, SHOW_CYCLES=4, POS_MAX=3.
- Reset hold: pbl=1 through reset and then held → no score_l/score_r pulse. lit rises 16 cycles after release with pos=3.
- Fair point: pbr pulses 5 cycles after lit rises → score_r high for exactly 1 cycle and pos=4. state is SCORE for 4 cycles, then DARK, and lit returns 16 cycles later.
- False start: pbl pulses at DARK cycle 7 → score_r pulse and pos=4. lit never rises in that round.
- Simultaneous press: pbl and pbr rise together in LIT → no pulse, pos unchanged, state=DARK with cnt restarted. Repeat the check in DARK: state stays DARK with cnt=0.
- Win: three consecutive left points → pos=0 and, after SCORE, winner=01 and state=WIN. Further pushes leave pos=0 and winner=01 for 50 cycles; rst=0 returns pos=3 and winner=00.
- Reset mid-SCORE: assert rst on the 2nd SCORE cycle → the next cycle shows state=DARK, pos=3 and no pulses.

Source files
------------

// File: rtl/tug_round_controller.sv
// Tug of War round controller.
// Runs each round: a dark wait, the go light, then a short score display.
// Presses before the light are false starts and give the point to the other
// player. Presses in the same cycle cancel each other and restart the round.
// Keeps the rope position and holds the winner until reset.
module tug_round_controller #(
  parameter int unsigned DARK_CYCLES = 16,
  parameter int unsigned SHOW_CYCLES = 4,
  parameter int unsigned POS_MAX     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pbl,
  input  logic       pbr,
  output logic       lit,
  output logic [3:0] pos,
  output logic       score_l,
  output logic       score_r,
  output logic [1:0] winner,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_DARK  = 2'b00,
    ST_LIT   = 2'b01,
    ST_SCORE = 2'b10,
    ST_WIN   = 2'b11
  } state_t;

  localparam logic [15:0] DARK_LAST  = 16'(DARK_CYCLES - 1);
  localparam logic [15:0] SHOW_LAST  = 16'(SHOW_CYCLES - 1);
  localparam logic [3:0]  POS_CENTRE = 4'(POS_MAX);
  localparam logic [3:0]  POS_RIGHT  = 4'(2 * POS_MAX);

  state_t      state_q;
  logic [15:0] cnt;
  logic        prevl;
  logic        prevr;
  logic        edge_l;
  logic        edge_r;

  // Rising-edge detect on the already-synchronized push buttons.
  assign edge_l = pbl & ~prevl;
  assign edge_r = pbr & ~prevr;

  assign state = state_q;

  // Round sequencer: state, counter, rope position and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: every register in a clocked block is written with <= so all of
      // them see the pre-edge values; blocking = here would create ordering races.
      state_q <= ST_DARK;
      cnt     <= '0;
      pos     <= POS_CENTRE;
      lit     <= 1'b0;
      score_l <= 1'b0;
      score_r <= 1'b0;
      winner  <= 2'b00;
      // Held buttons must be released before they can score again.
      prevl   <= 1'b1;
      prevr   <= 1'b1;
    end else begin
      prevl   <= pbl;
      prevr   <= pbr;
      score_l <= 1'b0;
      score_r <= 1'b0;

      case (state_q)
        ST_DARK: begin
          if (edge_l && edge_r) begin
            // Simultaneous early presses cancel out; restart the dark wait.
            cnt <= '0;
          end else if (edge_l) begin
            // Left jumped the gun: point to the right player.
            pos     <= pos + 4'd1;
            score_r <= 1'b1;
            state_q <= ST_SCORE;
            cnt     <= '0;
          end else if (edge_r) begin
            pos     <= pos - 4'd1;
            score_l <= 1'b1;
            state_q <= ST_SCORE;
            cnt     <= '0;
          end else if (cnt == DARK_LAST) begin
            state_q <= ST_LIT;
            lit     <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        ST_LIT: begin
          if (edge_l && edge_r) begin
            // Tie: no point, back to a fresh dark wait.
            state_q <= ST_DARK;
            lit     <= 1'b0;
            cnt     <= '0;
          end else if (edge_l) begin
            pos     <= pos - 4'd1;
            score_l <= 1'b1;
            state_q <= ST_SCORE;
            lit     <= 1'b0;
            cnt     <= '0;
          end else if (edge_r) begin
            pos     <= pos + 4'd1;
            score_r <= 1'b1;
            state_q <= ST_SCORE;
            lit     <= 1'b0;
            cnt     <= '0;
          end
        end

        ST_SCORE: begin
          if (cnt == SHOW_LAST) begin
            cnt <= '0;
            if (pos == 4'd0) begin
              state_q <= ST_WIN;
              winner  <= 2'b01;
            end else if (pos == POS_RIGHT) begin
              state_q <= ST_WIN;
              winner  <= 2'b10;
            end else begin
              state_q <= ST_DARK;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        ST_WIN: begin
          // Terminal: position and winner hold until reset.
          cnt <= '0;
        end

        default: begin
          state_q <= ST_DARK;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tug_round_controller.sv
// Directed self-checking bench for tug_round_controller.
// Score pulses are predicted into a queue when a press is driven and
// popped by a monitor when the DUT pulses score_l/score_r.
module tb_tug_round_controller;

  logic       clk;
  logic       rst;
  logic       pbl;
  logic       pbr;
  logic       lit;
  logic [3:0] pos;
  logic       score_l;
  logic       score_r;
  logic [1:0] winner;
  logic [1:0] state;

  typedef struct packed {
    logic       sl;
    logic       sr;
    logic [3:0] pos;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  tug_round_controller #(
    .DARK_CYCLES(16),
    .SHOW_CYCLES(4),
    .POS_MAX(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pbl    (pbl),
    .pbr    (pbr),
    .lit    (lit),
    .pos    (pos),
    .score_l(score_l),
    .score_r(score_r),
    .winner (winner),
    .state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_lit(input int budget);
    int n = 0;
    while (lit !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("wait_lit", 8'(lit), 8'd1);
  endtask

  // Scoreboard monitor: every score pulse must match a predicted point.
  always @(negedge clk) begin
    if (score_l === 1'b1 || score_r === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 8'({score_l, score_r}), 8'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse", 8'({score_l, score_r, pos}), 8'({e.sl, e.sr, e.pos}));
      end
    end
  end

  initial begin
    rst = 1'b0;
    pbl = 1'b1;
    pbr = 1'b0;

    // Reset hold with pbl held high throughout.
    repeat (3) step();
    check("rst_state", 8'(state), 8'd0);
    check("rst_pos", 8'(pos), 8'd3);
    check("rst_lit", 8'(lit), 8'd0);
    check("rst_winner", 8'(winner), 8'd0);
    check("rst_scores", 8'({score_l, score_r}), 8'd0);
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("lit_after_release", 8'(lit), 8'(i == 16));
    end
    check("pos_at_first_lit", 8'(pos), 8'd3);
    pbl = 1'b0;

    // Fair point: right presses 5 cycles after lit.
    repeat (4) step();
    check("lit_waiting", 8'(lit), 8'd1);
    pbr = 1'b1;
    sb.push_back('{sl: 1'b0, sr: 1'b1, pos: 4'd4});
    step();
    check("fair_score_r", 8'(score_r), 8'd1);
    check("fair_pos", 8'(pos), 8'd4);
    pbr = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("fair_score_state", 8'(state), 8'd2);
      check("fair_score_lit", 8'(lit), 8'd0);
      step();
    end
    check("fair_back_dark", 8'(state), 8'd0);
    check("fair_pulse_gone", 8'(score_r), 8'd0);

    // False start: left presses in the 7th DARK cycle.
    repeat (6) begin
      step();
      check("fs_lit_low", 8'(lit), 8'd0);
    end
    pbl = 1'b1;
    sb.push_back('{sl: 1'b0, sr: 1'b1, pos: 4'd5});
    step();
    check("fs_state", 8'(state), 8'd2);
    check("fs_pos", 8'(pos), 8'd5);
    check("fs_lit", 8'(lit), 8'd0);
    pbl = 1'b0;
    repeat (4) begin
      check("fs_score_lit", 8'(lit), 8'd0);
      step();
    end
    check("fs_back_dark", 8'(state), 8'd0);

    // Simultaneous press in DARK: counter restarts.
    repeat (5) step();
    pbl = 1'b1;
    pbr = 1'b1;
    step();
    check("dark_tie_state", 8'(state), 8'd0);
    check("dark_tie_pos", 8'(pos), 8'd5);
    pbl = 1'b0;
    pbr = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("dark_tie_relit", 8'(lit), 8'(i == 16));
    end

    // Simultaneous press in LIT: tie back to DARK.
    repeat (2) step();
    pbl = 1'b1;
    pbr = 1'b1;
    step();
    check("lit_tie_state", 8'(state), 8'd0);
    check("lit_tie_lit", 8'(lit), 8'd0);
    check("lit_tie_pos", 8'(pos), 8'd5);
    pbl = 1'b0;
    pbr = 1'b0;
    step();
    check("lit_tie_stay_dark", 8'(state), 8'd0);

    // Reset back to centre.
    rst = 1'b0;
    step();
    check("rst2_pos", 8'(pos), 8'd3);
    check("rst2_state", 8'(state), 8'd0);
    rst = 1'b1;

    // Win: three consecutive left points.
    for (int j = 0; j < 3; j++) begin
      wait_lit(40);
      pbl = 1'b1;
      sb.push_back('{sl: 1'b1, sr: 1'b0, pos: 4'(2 - j)});
      step();
      check("win_score_l", 8'(score_l), 8'd1);
      check("win_pos", 8'(pos), 8'(2 - j));
      pbl = 1'b0;
      repeat (3) step();
      check("win_in_score", 8'(state), 8'd2);
      step();
      check("win_after_score", 8'(state), (j == 2) ? 8'd3 : 8'd0);
    end
    check("win_winner", 8'(winner), 8'd1);
    check("win_lit", 8'(lit), 8'd0);

    // Pushes in WIN are ignored.
    for (int i = 0; i < 50; i++) begin
      pbl = i[0];
      pbr = i[1];
      step();
      check("win_hold_pos", 8'(pos), 8'd0);
      check("win_hold_winner", 8'(winner), 8'd1);
    end
    check("win_hold_state", 8'(state), 8'd3);
    pbl = 1'b0;
    pbr = 1'b0;
    rst = 1'b0;
    step();
    check("win_rst_pos", 8'(pos), 8'd3);
    check("win_rst_winner", 8'(winner), 8'd0);
    check("win_rst_state", 8'(state), 8'd0);
    rst = 1'b1;

    // Reset in the 2nd SCORE cycle.
    wait_lit(40);
    pbr = 1'b1;
    sb.push_back('{sl: 1'b0, sr: 1'b1, pos: 4'd4});
    step();
    pbr = 1'b0;
    step();
    check("mid_score_state", 8'(state), 8'd2);
    rst = 1'b0;
    step();
    check("mid_rst_state", 8'(state), 8'd0);
    check("mid_rst_pos", 8'(pos), 8'd3);
    check("mid_rst_pulses", 8'({score_l, score_r}), 8'd0);
    rst = 1'b1;
    repeat (3) step();
    check("scoreboard_drained", 8'(sb.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
